// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the round-robin adder arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_arb_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NREQ_DEF  = 4;
    localparam int ID_W      = $clog2(NREQ_DEF);
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Round-robin priority picker: first set req bit at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   gnt_id,
    output logic            gnt_any
);

    // Scan from lowest priority to highest so the last hit (closest to ptr) wins.
    always_comb begin
        int idx;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                gnt_id  = IW'(idx);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one carry-lookahead adder among NREQ requesters with round-robin grant.
// Latency: accept in IDLE, sum registered in CALC, response offered in RESP (3 cycles min).
// Backpressure: RESP holds until the owner's rsp_ready; no request accepted outside IDLE.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_carry,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        done_cnt
);

    localparam int IW = $clog2(NREQ);

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    id_q;
    logic [IW-1:0]    gnt_id;
    logic             gnt_any;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [WIDTH-1:0] cla_sum;
    logic             cla_carry;
    logic             accept;
    logic             rsp_done;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    // Parallel-prefix carry lookahead on the latched operands; g[i] ends as carry out of bit i.
    always_comb begin
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] x;
        x = a_q ^ b_q;
        g = a_q & b_q;
        p = x;
        for (int d = 1; d < WIDTH; d = d * 2) begin
            for (int i = WIDTH - 1; i >= d; i--) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        cla_sum   = x ^ {g[WIDTH-2:0], 1'b0};
        cla_carry = g[WIDTH-1];
    end

    // Next-state and handshake decode; only IDLE grants, only RESP offers a result.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    req_ready[gnt_id] = 1'b1;
                    accept            = 1'b1;
                    state_nxt         = CALC;
                end
            end
            CALC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[id_q] = 1'b1;
                if (rsp_ready[id_q]) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand/result capture, completion count and pointer advance on response completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            rr_ptr   <= '0;
            done_cnt <= '0;
        end else begin
            if (accept) begin
                a_q  <= req_a[gnt_id*WIDTH +: WIDTH];
                b_q  <= req_b[gnt_id*WIDTH +: WIDTH];
                id_q <= gnt_id;
            end
            if (state == CALC) begin
                sum_q   <= cla_sum;
                carry_q <= cla_carry;
            end
            if (rsp_done) begin
                done_cnt <= done_cnt + 1'b1;
                rr_ptr   <= (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
    assign rsp_id    = id_q;
    assign busy      = (state != IDLE);

endmodule
